eight_data_decompress_unit: RTL and testbench

- Receive side of the 8-word compression path.
- Accepts one compressed block per handshake: a byte-packed 256-bit payload, 16 bits of 2-bit per-word tags and a byte length.
- Rebuilds the eight 32-bit words through a 2-stage valid/ready pipeline.
- Sits between the compressed-stream buffer and the data consumer, and gives one block per cycle at full rate.

---
 rtl/eight_data_decompress_unit.sv | 148 ++++++++++++++
 tb/tb_eight_data_decompress_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eight_data_decompress_unit.sv
// eight_data_decompress_unit
// Receive-side decompressor: rebuilds NUM_WORDS 32-bit words from a byte-packed
// payload plus 2-bit per-word tags, through a 2-stage valid/ready pipeline.
// Optional build macro: DECOMPRESS_LEN_CHECK_EN
//   defined   -> lenIn is registered and compared with the computed length; errOut flags a mismatch
//   undefined -> lenIn is ignored and errOut is always 0
module eight_data_decompress_unit #(
    parameter int NUM_WORDS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [32*NUM_WORDS-1:0] cprDataIn,
    input  logic [2*NUM_WORDS-1:0]  tagIn,
    input  logic [7:0]              lenIn,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [32*NUM_WORDS-1:0] dataOut,
    output logic [2*NUM_WORDS-1:0]  tagOut,
    output logic [7:0]              lenOut,
    output logic                    errOut
);
    localparam int DW = 32 * NUM_WORDS;
    localparam int TW = 2 * NUM_WORDS;

    // Handshake signals
    logic          bLoad;
    logic          aLoad;

    // Stage A state
    logic          aValidReg;
    logic [DW-1:0] aDataReg;
    logic [TW-1:0] aTagReg;
    logic [7:0]    aOffsetReg [NUM_WORDS];
    logic [7:0]    aTotalReg;

    // Stage A combinational length/offset computation
    logic [7:0]    inConsumed [NUM_WORDS];
    logic [7:0]    inOffset   [NUM_WORDS];
    logic [7:0]    inTotal;

    // Stage B combinational results
    logic [DW-1:0] bDataNext;
    logic          bErr;

    // Stage B can take a new block when empty or when its block is being consumed
    assign bLoad   = !outValid || outReady;
    assign inReady = !aValidReg || bLoad;
    assign aLoad   = inValid && inReady;

    // Bytes consumed by each word, straight from its tag
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : gConsumed
            assign inConsumed[gi] = (tagIn[2*gi+1:2*gi] == 2'b11) ? 8'd4
                                                                  : {6'd0, tagIn[2*gi+1:2*gi]};
        end
    endgenerate

    // Prefix sum of consumed bytes; the top word starts at byte 0 (MSB end of the payload)
    always_comb begin
        inOffset[NUM_WORDS-1] = 8'd0;
        for (int i = NUM_WORDS - 2; i >= 0; i--) begin
            inOffset[i] = inOffset[i+1] + inConsumed[i+1];
        end
        inTotal = inOffset[0] + inConsumed[0];
    end

    // Stage A occupancy: fill on accept, drain when its block moves to stage B
    always_ff @(posedge clk) begin
        if (reset) begin
            aValidReg <= 1'b0;
        end else if (aLoad) begin
            aValidReg <= 1'b1;
        end else if (bLoad) begin
            aValidReg <= 1'b0;
        end
    end

    // Stage A payload registers; only written on accept so they hold while stalled
    always_ff @(posedge clk) begin
        if (aLoad) begin
            aDataReg   <= cprDataIn;
            aTagReg    <= tagIn;
            aOffsetReg <= inOffset;
            aTotalReg  <= inTotal;
        end
    end

`ifdef DECOMPRESS_LEN_CHECK_EN
    logic [7:0] aLenReg;

    // Declared length travels with the block for the stage-B comparison
    always_ff @(posedge clk) begin
        if (aLoad) begin
            aLenReg <= lenIn;
        end
    end

    assign bErr = (aLenReg != aTotalReg);
`else
    logic unusedLen;
    assign unusedLen = ^lenIn;
    assign bErr      = 1'b0;
`endif

    // Per-word extraction: byte-granular left shift brings the word's first byte to the top
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : gExtract
            logic [31:0] topWord;
            logic [31:0] maskedWord;

            assign topWord = 32'((aDataReg << {aOffsetReg[gi], 3'b000}) >> (DW - 32));

            // Keep only the bytes this word actually consumed
            always_comb begin
                case (aTagReg[2*gi+1:2*gi])
                    2'b00:   maskedWord = 32'd0;
                    2'b01:   maskedWord = {topWord[31:24], 24'd0};
                    2'b10:   maskedWord = {topWord[31:16], 16'd0};
                    default: maskedWord = topWord;
                endcase
            end

            assign bDataNext[32*gi +: 32] = maskedWord;
        end
    endgenerate

    // Stage B output registers: load from stage A when allowed, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid <= 1'b0;
            dataOut  <= '0;
            tagOut   <= '0;
            lenOut   <= 8'd0;
            errOut   <= 1'b0;
        end else if (bLoad) begin
            outValid <= aValidReg;
            if (aValidReg) begin
                dataOut <= bDataNext;
                tagOut  <= aTagReg;
                lenOut  <= aTotalReg;
                errOut  <= bErr;
            end
        end
    end

endmodule

// File: tb/tb_eight_data_decompress_unit.sv
// tb_eight_data_decompress_unit
// Table-driven vectors plus hand-written latency, backpressure and reset sequences.
// Expected results are queued at handshake time and compared when the block emerges.
// Build with DECOMPRESS_LEN_CHECK_EN defined to expect errOut on length mismatch.
module tb_eight_data_decompress_unit;
    localparam int NW   = 8;
    localparam int DW   = 32 * NW;
    localparam int TW   = 2 * NW;
    localparam int NVEC = 8;
`ifdef DECOMPRESS_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic [7:0]    len;
        logic [DW-1:0] expData;
        logic [7:0]    expLen;
        logic          expErr;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          inValid;
    logic          inReady;
    logic [DW-1:0] cprDataIn;
    logic [TW-1:0] tagIn;
    logic [7:0]    lenIn;
    logic          outValid;
    logic          outReady;
    logic [DW-1:0] dataOut;
    logic [TW-1:0] tagOut;
    logic [7:0]    lenOut;
    logic          errOut;

    int   total = 0;
    int   bad = 0;
    int   popCount = 0;
    vec_t expQ[$];
    vec_t drvVec;
    vec_t monE;
    vec_t vecs[NVEC];
    vec_t bpVecs[4];
    vec_t rsVecs[2];
    vec_t recVec;

    logic [DW-1:0] holdData;
    logic [TW-1:0] holdTag;
    logic [7:0]    holdLen;
    logic          holdErr;
    bit            holdValid = 1'b0;

    eight_data_decompress_unit #(.NUM_WORDS(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .cprDataIn (cprDataIn),
        .tagIn     (tagIn),
        .lenIn     (lenIn),
        .outValid  (outValid),
        .outReady  (outReady),
        .dataOut   (dataOut),
        .tagOut    (tagOut),
        .lenOut    (lenOut),
        .errOut    (errOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference decoder: walks a byte pointer from the MSB end of the payload
    function automatic void model(input logic [DW-1:0] d, input logic [TW-1:0] t,
                                  output logic [DW-1:0] words, output logic [7:0] len);
        int ptr;
        ptr = 0;
        words = '0;
        for (int w = NW - 1; w >= 0; w--) begin
            logic [1:0] tg;
            int n;
            tg = t[2*w +: 2];
            n = (tg == 2'b11) ? 4 : int'(tg);
            for (int b = 0; b < n; b++) begin
                words[32*w + 31 - 8*b -: 8] = d[DW - 1 - 8*(ptr + b) -: 8];
            end
            ptr += n;
        end
        len = 8'(ptr);
    endfunction

    function automatic vec_t mkHand(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic [7:0] l,
                                    input logic [DW-1:0] ed, input logic [7:0] el, input logic errIfChecked);
        vec_t v;
        v.data = d; v.tag = t; v.len = l;
        v.expData = ed; v.expLen = el;
        v.expErr = LEN_CHECK ? errIfChecked : 1'b0;
        return v;
    endfunction

    function automatic vec_t mkModel(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic [7:0] l);
        vec_t v;
        logic [DW-1:0] w;
        logic [7:0] n;
        model(d, t, w, n);
        v.data = d; v.tag = t; v.len = l;
        v.expData = w; v.expLen = n;
        v.expErr = LEN_CHECK && (l != n);
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int i = 0; i < NW; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Monitor: stability under stall, scoreboard pop on emit, scoreboard push on accept
    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
            holdValid = 1'b0;
        end else begin
            if (holdValid) begin
                chk("stall_valid", DW'(outValid), DW'(1'b1));
                chk("stall_data", dataOut, holdData);
                chk("stall_tag", DW'(tagOut), DW'(holdTag));
                chk("stall_len", DW'(lenOut), DW'(holdLen));
                chk("stall_err", DW'(errOut), DW'(holdErr));
            end
            holdValid = outValid && !outReady;
            holdData  = dataOut;
            holdTag   = tagOut;
            holdLen   = lenOut;
            holdErr   = errOut;
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: actual=%0h required=none", dataOut);
                end else begin
                    monE = expQ.pop_front();
                    popCount++;
                    $display("out #%0d tag=%h data=%h len=%h err=%b", popCount, tagOut, dataOut, lenOut, errOut);
                    chk("out_data", dataOut, monE.expData);
                    chk("out_tag", DW'(tagOut), DW'(monE.tag));
                    chk("out_len", DW'(lenOut), DW'(monE.expLen));
                    chk("out_err", DW'(errOut), DW'(monE.expErr));
                end
            end
            if (inValid && inReady) expQ.push_back(drvVec);
        end
    end

    // Present a block starting at posedge+1; returns at posedge+1 after it is accepted
    task automatic drive(input vec_t v, output int waited);
        waited = 0;
        drvVec = v;
        cprDataIn = v.data;
        tagIn = v.tag;
        lenIn = v.len;
        inValid = 1'b1;
        @(negedge clk);
        while (!inReady && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!inReady) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: actual=inReady 0 required=inReady 1");
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || outValid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (expQ.size() != 0 || outValid) begin
            bad++;
            $display("FAIL drain_timeout: actual=%0d pending required=0 pending", expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        int base;
        logic [DW-1:0] mixedData;
        logic [DW-1:0] mixedExp;
        logic [DW-1:0] fullData;

        mixedData = {120'h123456789ABCDEF123456789ABCDEF, 136'h0};
        mixedExp  = {32'h12000000, 32'h00000000, 32'h34000000, 32'h56780000,
                     32'h9ABCDEF1, 32'h23000000, 32'h45670000, 32'h89ABCDEF};
        fullData  = 256'h1234_5678_9ABC_DEF1_2345_6789_ABCD_EF12_3456_789A_BCDE_F123_4567_89AB_CDEF_1234;

        vecs[0] = mkHand(mixedData, 16'b0100011011011011, 8'h0F, mixedExp, 8'h0F, 1'b0);
        vecs[1] = mkHand({DW{1'b1}}, 16'h0000, 8'h00, '0, 8'h00, 1'b0);
        vecs[2] = mkHand(fullData, 16'hFFFF, 8'h20, fullData, 8'h20, 1'b0);
        vecs[3] = mkHand(mixedData, 16'b0100011011011011, 8'h0E, mixedExp, 8'h0F, 1'b1);
        vecs[4] = mkModel(rnd256(), 16'($urandom()), 8'h00);
        vecs[4].len = vecs[4].expLen;
        vecs[4].expErr = 1'b0;
        vecs[5] = mkModel(rnd256(), 16'($urandom()), 8'($urandom()));
        vecs[6] = mkModel(rnd256(), 16'hAAAA, 8'h10);
        vecs[7] = mkModel(rnd256(), 16'h5555, 8'h09);
        for (int i = 0; i < 4; i++) bpVecs[i] = mkModel(rnd256(), 16'($urandom()), 8'($urandom_range(0, 32)));
        for (int i = 0; i < 2; i++) rsVecs[i] = mkModel(rnd256(), 16'($urandom()), 8'h00);
        recVec = mkModel(rnd256(), 16'hD8E4, 8'h00);

        reset = 1'b1;
        inValid = 1'b0;
        outReady = 1'b1;
        cprDataIn = '0;
        tagIn = '0;
        lenIn = 8'h00;
        drvVec = vecs[0];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outvalid", DW'(outValid), DW'(1'b0));
        chk("rst_data", dataOut, '0);
        chk("rst_tag", DW'(tagOut), '0);
        chk("rst_len", DW'(lenOut), '0);
        chk("rst_err", DW'(errOut), '0);
        chk("rst_inready", DW'(inReady), DW'(1'b1));

        // Latency: handshake cycle c, outValid seen in cycle c+2
        @(posedge clk);
        #1;
        drvVec = vecs[0];
        cprDataIn = vecs[0].data;
        tagIn = vecs[0].tag;
        lenIn = vecs[0].len;
        inValid = 1'b1;
        @(negedge clk);
        chk("lat_inready", DW'(inReady), DW'(1'b1));
        @(posedge clk);
        #1;
        inValid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_outvalid", DW'(outValid), DW'(1'b0));
        @(negedge clk);
        chk("lat_cycle2_outvalid", DW'(outValid), DW'(1'b1));
        waitDrain();

        // Vector table streamed at full rate
        base = popCount;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i], waited);
            chk("full_rate_wait", DW'(waited), '0);
        end
        waitDrain();
        chk("table_count", DW'(popCount - base), DW'(NVEC));

        // Backpressure: 4 blocks back-to-back, consumer stalls 3 cycles on the first result
        base = popCount;
        fork
            begin
                int w;
                for (int i = 0; i < 4; i++) drive(bpVecs[i], w);
            end
            begin
                int n;
                n = 0;
                while (!outValid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("bp_first_out", DW'(outValid), DW'(1'b1));
                outReady = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_inready_low", DW'(inReady), DW'(1'b0));
                    @(posedge clk);
                    #1;
                end
                outReady = 1'b1;
            end
        join
        waitDrain();
        chk("bp_count", DW'(popCount - base), DW'(4));

        // Mid-stream reset with both stages occupied
        outReady = 1'b0;
        drive(rsVecs[0], waited);
        drive(rsVecs[1], waited);
        chk("rs_pre_outvalid", DW'(outValid), DW'(1'b1));
        chk("rs_pre_inready", DW'(inReady), DW'(1'b0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rs_outvalid", DW'(outValid), DW'(1'b0));
        chk("rs_data", dataOut, '0);
        chk("rs_tag", DW'(tagOut), '0);
        chk("rs_len", DW'(lenOut), '0);
        chk("rs_err", DW'(errOut), '0);
        chk("rs_inready", DW'(inReady), DW'(1'b1));
        outReady = 1'b1;
        repeat (4) @(negedge clk);
        chk("rs_no_ghost", DW'(outValid), DW'(1'b0));
        @(posedge clk);
        #1;
        base = popCount;
        drive(recVec, waited);
        waitDrain();
        chk("rs_recover_count", DW'(popCount - base), DW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
